// File: rtl/seq_code_checker.sv
// Receive-side checker for the 4-bit count code 1,3,7,A,C,F,2,9.
// Ports: clk, rst (sync, active-high), in_valid, in_value[3:0] in;
//   index[2:0], locked, err_pulse, err_count[ERR_W-1:0], wrap_pulse, illegal out.
module seq_code_checker #(
   parameter int LOCK_COUNT  = 3,
   parameter int UNLOCK_ERRS = 2,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [3:0]       in_value,
   output logic [2:0]       index,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic             wrap_pulse,
   output logic             illegal
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(UNLOCK_ERRS + 1);
   localparam logic [GW-1:0] LOCK_C = GW'(LOCK_COUNT);
   localparam logic [BW-1:0] UNLK_C = BW'(UNLOCK_ERRS);

   typedef enum logic [1:0] {
      HUNT,
      VERIFY,
      LOCKED
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       anchor_q, anchor_d;
   logic [GW-1:0]    good_q, good_d;
   logic [BW-1:0]    bad_q, bad_d;
   logic [2:0]       index_q, index_d;
   logic             locked_q, locked_d;
   logic             err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic             wrap_q, wrap_d;
   logic             illegal_q, illegal_d;

   logic       legal;
   logic [2:0] dec;
   logic [2:0] exp_idx;
   logic       correct;

   always_comb begin
      legal = 1'b1;
      dec   = 3'd0;
      case (in_value)
         4'h1:    dec = 3'd0;
         4'h3:    dec = 3'd1;
         4'h7:    dec = 3'd2;
         4'hA:    dec = 3'd3;
         4'hC:    dec = 3'd4;
         4'hF:    dec = 3'd5;
         4'h2:    dec = 3'd6;
         4'h9:    dec = 3'd7;
         default: legal = 1'b0;
      endcase
   end

   assign exp_idx = anchor_q + 3'd1;
   assign correct = legal && (dec == exp_idx);

   always_comb begin
      state_d     = state_q;
      anchor_d    = anchor_q;
      good_d      = good_q;
      bad_d       = bad_q;
      index_d     = index_q;
      err_count_d = err_count_q;
      err_pulse_d = 1'b0;
      wrap_d      = 1'b0;
      illegal_d   = 1'b0;
      if (in_valid) begin
         illegal_d = !legal;
         if (legal) index_d = dec;
         case (state_q)
            HUNT: begin
               if (legal) begin
                  anchor_d = dec;
                  good_d   = '0;
                  state_d  = VERIFY;
               end
            end
            VERIFY: begin
               if (correct) begin
                  anchor_d = exp_idx;
                  good_d   = good_q + GW'(1);
                  if (good_q + GW'(1) == LOCK_C) begin
                     state_d = LOCKED;
                     bad_d   = '0;
                  end
               end else if (legal) begin
                  anchor_d = dec;
                  good_d   = '0;
               end else begin
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               if (correct) begin
                  anchor_d = exp_idx;
                  bad_d    = '0;
                  wrap_d   = (exp_idx == 3'd0);
               end else begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != {ERR_W{1'b1}})
                     err_count_d = err_count_q + ERR_W'(1);
                  bad_d = bad_q + BW'(1);
                  // Resync on a legal wrong code, flywheel past an illegal one
                  anchor_d = legal ? dec : exp_idx;
                  if (bad_q + BW'(1) == UNLK_C) state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         anchor_q    <= '0;
         good_q      <= '0;
         bad_q       <= '0;
         index_q     <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
         wrap_q      <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         anchor_q    <= anchor_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         index_q     <= index_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
         wrap_q      <= wrap_d;
         illegal_q   <= illegal_d;
      end
   end

   assign index      = index_q;
   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign err_count  = err_count_q;
   assign wrap_pulse = wrap_q;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_seq_code_checker.sv
// Directed bench for seq_code_checker.
// Second instance covers err_count saturation with a narrow counter.
module tb_seq_code_checker;

   logic       clk = 1'b0;
   logic       rst, in_valid;
   logic [3:0] in_value;
   logic [2:0] index;
   logic       locked, err_pulse, wrap_pulse, illegal;
   logic [7:0] err_count;

   logic       rst2, in_valid2;
   logic [3:0] in_value2;
   logic [2:0] index2;
   logic       locked2, err_pulse2, wrap_pulse2, illegal2;
   logic [1:0] err_count2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seq_code_checker dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
      .index(index), .locked(locked), .err_pulse(err_pulse),
      .err_count(err_count), .wrap_pulse(wrap_pulse), .illegal(illegal)
   );

   seq_code_checker #(.LOCK_COUNT(3), .UNLOCK_ERRS(8), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_value(in_value2),
      .index(index2), .locked(locked2), .err_pulse(err_pulse2),
      .err_count(err_count2), .wrap_pulse(wrap_pulse2), .illegal(illegal2)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [3:0] c);
      in_valid = 1'b1;
      in_value = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic send2(input logic [3:0] c);
      in_valid2 = 1'b1;
      in_value2 = c;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
   endtask

   // idx, locked, err_pulse, err_count, wrap, illegal
   task automatic expect_all(input string tag, input logic [2:0] ix,
                             input logic lk, input logic ep,
                             input logic [7:0] ec, input logic wp,
                             input logic il);
      check({tag, ".index"}, index, ix);
      check({tag, ".locked"}, locked, lk);
      check({tag, ".err_pulse"}, err_pulse, ep);
      check({tag, ".err_count"}, err_count, ec);
      check({tag, ".wrap"}, wrap_pulse, wp);
      check({tag, ".illegal"}, illegal, il);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_value = 4'h0;
      rst2 = 1'b1; in_valid2 = 1'b0; in_value2 = 4'h0;
      idle();
      rst = 1'b0; rst2 = 1'b0;
      expect_all("reset", 3'd0, 0, 0, 8'd0, 0, 0);

      // 1) acquire lock
      send(4'h1); expect_all("t1_1", 3'd0, 0, 0, 8'd0, 0, 0);
      send(4'h3); expect_all("t1_3", 3'd1, 0, 0, 8'd0, 0, 0);
      send(4'h7); expect_all("t1_7", 3'd2, 0, 0, 8'd0, 0, 0);
      send(4'hA); expect_all("t1_A", 3'd3, 1, 0, 8'd0, 0, 0);

      // 2) full cycle with wrap
      send(4'hC); expect_all("t2_C", 3'd4, 1, 0, 8'd0, 0, 0);
      send(4'hF); expect_all("t2_F", 3'd5, 1, 0, 8'd0, 0, 0);
      send(4'h2); expect_all("t2_2", 3'd6, 1, 0, 8'd0, 0, 0);
      send(4'h9); expect_all("t2_9", 3'd7, 1, 0, 8'd0, 0, 0);
      send(4'h1); expect_all("t2_1", 3'd0, 1, 0, 8'd0, 1, 0);
      send(4'h3); expect_all("t2_3", 3'd1, 1, 0, 8'd0, 0, 0);

      // 3) skip then stale code -> two errors -> unlock
      send(4'h7); expect_all("t3_7", 3'd2, 1, 0, 8'd0, 0, 0);
      send(4'hC); expect_all("t3_C", 3'd4, 1, 1, 8'd1, 0, 0);
      send(4'hA); expect_all("t3_A", 3'd3, 0, 1, 8'd2, 0, 0);

      // 4) relock, flywheel over an illegal code
      send(4'h2); expect_all("t4_2", 3'd6, 0, 0, 8'd2, 0, 0);
      send(4'h9); send(4'h1);
      expect_all("t4_1", 3'd0, 0, 0, 8'd2, 0, 0);
      send(4'h3); expect_all("t4_3", 3'd1, 1, 0, 8'd2, 0, 0);
      send(4'h7); expect_all("t4_7", 3'd2, 1, 0, 8'd2, 0, 0);
      send(4'h0); expect_all("t4_0", 3'd2, 1, 1, 8'd3, 0, 1);
      send(4'hC); expect_all("t4_C", 3'd4, 1, 0, 8'd3, 0, 0);
      send(4'hF); expect_all("t4_F", 3'd5, 1, 0, 8'd3, 0, 0);
      // bad counter was cleared by the correct steps: one error stays locked
      send(4'hB); expect_all("t4_B", 3'd5, 1, 1, 8'd4, 0, 1);
      send(4'h9); expect_all("t4_9", 3'd7, 1, 0, 8'd4, 0, 0);

      // 5) idle with garbage on the bus
      in_value = 4'h0;
      for (int i = 0; i < 10; i++) begin
         idle();
         expect_all("t5_idle", 3'd7, 1, 0, 8'd4, 0, 0);
      end
      send(4'h1); expect_all("t5_wrap", 3'd0, 1, 0, 8'd4, 1, 0);

      // reset beats a valid sample
      rst = 1'b1; in_valid = 1'b1; in_value = 4'h3;
      idle();
      rst = 1'b0; in_valid = 1'b0;
      expect_all("t5_rst", 3'd0, 0, 0, 8'd0, 0, 0);

      // re-hunt; repeat and illegal in VERIFY restart the count
      send(4'h1); send(4'h3);
      send(4'h3); expect_all("t5_rep", 3'd1, 0, 0, 8'd0, 0, 0);
      send(4'h7); send(4'hA);
      expect_all("t5_A", 3'd3, 0, 0, 8'd0, 0, 0);
      send(4'h0); expect_all("t5_ill", 3'd3, 0, 0, 8'd0, 0, 1);
      send(4'hC); send(4'hF);
      send(4'h2); expect_all("t5_2", 3'd6, 0, 0, 8'd0, 0, 0);
      send(4'h9); expect_all("t5_9", 3'd7, 1, 0, 8'd0, 0, 0);
      // repeated code while locked is an error
      send(4'h9); expect_all("t5_rp9", 3'd7, 1, 1, 8'd1, 0, 0);
      send(4'h1); expect_all("t5_r1", 3'd0, 1, 0, 8'd1, 1, 0);

      // 6) narrow saturating counter
      check("t6_rst", err_count2, 2'd0);
      send2(4'h1); send2(4'h3); send2(4'h7); send2(4'hA);
      check("t6_lock", locked2, 1'b1);
      send2(4'h0); check("t6_e1", err_count2, 2'd1);
      send2(4'h0); check("t6_e2", err_count2, 2'd2);
      send2(4'h0); check("t6_e3", err_count2, 2'd3);
      send2(4'h0); check("t6_e4", err_count2, 2'd3);
      send2(4'h0); check("t6_e5", err_count2, 2'd3);
      check("t6_pulse", err_pulse2, 1'b1);
      check("t6_still", locked2, 1'b1);
      check("t6_idx", index2, 3'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
